// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store stage: FSM encoding, op
// classification and default timeout.
package lsu_pkg;

  localparam int XLEN                   = 32;
  localparam int REG_AW                 = 5;
  localparam int TIMEOUT_CYCLES_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    OP_ALU   = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } lsu_op_t;

  // A malformed op flagged as both load and store is executed as a load.
  function automatic lsu_op_t decode_op(input logic is_load, input logic is_s_instr);
    lsu_op_t op;
    op = OP_ALU;
    if (is_load) begin
      op = OP_LOAD;
    end else if (is_s_instr) begin
      op = OP_STORE;
    end
    return op;
  endfunction

endpackage

// File: rtl/lsu_timeout_ctr.sv
// Watchdog for the memory wait state: counts cycles while run is high and
// flags the last permitted cycle. Only built when LSU_TIMEOUT_EN is defined.
module lsu_timeout_ctr #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic expired
);

  localparam int unsigned   CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  // Saturates at LAST so a stalled consumer cannot wrap the count.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + CW'(1);
    end
  end

  assign expired = run && (count == LAST);

endmodule

// File: rtl/lsu_stage.sv
// Single-outstanding load/store stage: accepts one op, performs at most one
// data-memory access, then emits a one-cycle writeback. Optional macro
// LSU_TIMEOUT_EN aborts a memory access that is not acknowledged in time.
module lsu_stage
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              is_load,
  input  logic              is_s_instr,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   store_data,
  input  logic [REG_AW-1:0] rd_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              wb_valid,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              err
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("lsu_stage: TIMEOUT_CYCLES must be nonzero");
  end

  lsu_state_t        state;
  lsu_state_t        state_next;
  lsu_op_t           op_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   rdata_q;
  logic [REG_AW-1:0] rd_q;
  logic              accept;
  logic              ack_in_wait;
  logic              timeout_hit;
  logic              err_flag;

  assign in_ready    = (state == IDLE) && !reset;
  assign accept      = in_valid && in_ready;
  assign ack_in_wait = (state == WAIT) && mem_ack;

`ifdef LSU_TIMEOUT_EN
  logic err_q;

  lsu_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk     (clk),
    .reset   (reset),
    .run     (state == WAIT),
    .expired (timeout_hit)
  );

  // An ack arriving on the final permitted cycle still wins over the abort.
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      err_q <= 1'b0;
    end else if ((state == WAIT) && !mem_ack && timeout_hit) begin
      err_q <= 1'b1;
    end
  end

  assign err_flag = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err_flag    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand capture at accept; load data is cleared so an aborted load
  // never writes back data left over from an earlier access.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= OP_ALU;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= '0;
    end else begin
      if (accept) begin
        op_q    <= decode_op(is_load, is_s_instr);
        addr_q  <= alu_result;
        wdata_q <= store_data;
        rd_q    <= rd_in;
        rdata_q <= '0;
      end
      if (ack_in_wait) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    wb_valid   = 1'b0;
    wb_en      = 1'b0;
    wb_rd      = '0;
    wb_data    = '0;
    err        = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = (decode_op(is_load, is_s_instr) == OP_ALU) ? RESP : WAIT;
        end
      end
      WAIT: begin
        mem_req   = 1'b1;
        mem_we    = (op_q == OP_STORE);
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (mem_ack || timeout_hit) begin
          state_next = RESP;
        end
      end
      RESP: begin
        wb_valid   = 1'b1;
        wb_rd      = rd_q;
        wb_data    = (op_q == OP_LOAD) ? rdata_q : addr_q;
        wb_en      = (op_q != OP_STORE) && (rd_q != '0) && !err_flag;
        err        = err_flag;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lsu_stage.sv
// Self-checking bench for lsu_stage: expected writebacks are queued at issue
// and popped by a monitor whenever wb_valid is seen.
module tb_lsu_stage;

  localparam int TB_TIMEOUT = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        en;
    logic        err;
  } wb_exp_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        is_load;
  logic        is_s_instr;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  rd_in;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;

  int      checks   = 0;
  int      fails    = 0;
  int      wb_count = 0;
  wb_exp_t exp_q[$];
  wb_exp_t mon_e;

  lsu_stage #(
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .is_load    (is_load),
    .is_s_instr (is_s_instr),
    .alu_result (alu_result),
    .store_data (store_data),
    .rd_in      (rd_in),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .wb_valid   (wb_valid),
    .wb_en      (wb_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scoreboard monitor: every writeback pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      wb_count++;
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL wb_unexpected: got rd=%0d data=%h en=%b err=%b, required no writeback",
                 wb_rd, wb_data, wb_en, err);
      end else begin
        mon_e = exp_q.pop_front();
        if ({wb_rd, wb_data, wb_en, err} !== {mon_e.rd, mon_e.data, mon_e.en, mon_e.err}) begin
          fails++;
          $display("[TB] FAIL wb_match: got rd=%0d data=%h en=%b err=%b, required rd=%0d data=%h en=%b err=%b",
                   wb_rd, wb_data, wb_en, err, mon_e.rd, mon_e.data, mon_e.en, mon_e.err);
        end
      end
    end
  end

  // Presents one op at the current negedge; returns one negedge after accept.
  task automatic drive_op(input logic ld, input logic st, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd);
    in_valid   = 1'b1;
    is_load    = ld;
    is_s_instr = st;
    alu_result = addr;
    store_data = wdata;
    rd_in      = rd;
    @(negedge clk);
    in_valid   = 1'b0;
    is_load    = 1'b0;
    is_s_instr = 1'b0;
    alu_result = '0;
    store_data = '0;
    rd_in      = '0;
  endtask

  task automatic test_reset();
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_en, wb_rd, wb_data, err, in_ready} !== '0) begin
        fails++;
        $display("[TB] FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h wbv=%b en=%b rd=%0d data=%h err=%b rdy=%b, required all 0",
                 mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_en, wb_rd, wb_data, err, in_ready);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_release_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_alu();
    exp_q.push_back('{rd: 5'd3, data: 32'h0000_0005, en: 1'b1, err: 1'b0});
    drive_op(1'b0, 1'b0, 32'h0000_0005, 32'h0, 5'd3);
    checks++;
    if ({wb_valid, mem_req} !== 2'b10) begin
      fails++;
      $display("[TB] FAIL alu_latency: got wb_valid=%b mem_req=%b, required 1 0", wb_valid, mem_req);
    end
    @(negedge clk);
    checks++;
    if ({wb_valid, in_ready} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL alu_single_pulse: got wb_valid=%b in_ready=%b, required 0 1", wb_valid, in_ready);
    end
    exp_q.push_back('{rd: 5'd0, data: 32'hFFFF_FFF0, en: 1'b0, err: 1'b0});
    drive_op(1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0, 5'd0);
    @(negedge clk);
  endtask

  task automatic test_load();
    exp_q.push_back('{rd: 5'd4, data: 32'hDEAD_BEEF, en: 1'b1, err: 1'b0});
    drive_op(1'b1, 1'b0, 32'h0000_0100, 32'hAAAA_5555, 5'd4);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({mem_req, mem_we, mem_addr, in_ready, wb_valid} !== {1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0}) begin
        fails++;
        $display("[TB] FAIL load_wait: cycle %0d got req=%b we=%b addr=%h rdy=%b wbv=%b, required 1 0 00000100 0 0",
                 i, mem_req, mem_we, mem_addr, in_ready, wb_valid);
      end
      if (i == 2) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
      end
      @(negedge clk);
    end
    mem_ack   = 1'b0;
    mem_rdata = '0;
    checks++;
    if ({wb_valid, mem_req, mem_addr, mem_we} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      fails++;
      $display("[TB] FAIL load_resp: got wbv=%b req=%b addr=%h we=%b, required 1 0 00000000 0",
               wb_valid, mem_req, mem_addr, mem_we);
    end
    @(negedge clk);
  endtask

  task automatic test_both_flags();
    exp_q.push_back('{rd: 5'd6, data: 32'hCAFE_0000, en: 1'b1, err: 1'b0});
    drive_op(1'b1, 1'b1, 32'h0000_0300, 32'h0000_0077, 5'd6);
    checks++;
    if ({mem_req, mem_we} !== 2'b10) begin
      fails++;
      $display("[TB] FAIL both_flags_is_load: got req=%b we=%b, required 1 0", mem_req, mem_we);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_0000;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = '0;
    @(negedge clk);
  endtask

  task automatic test_store();
    exp_q.push_back('{rd: 5'd7, data: 32'h0000_0200, en: 1'b0, err: 1'b0});
    drive_op(1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 5'd7);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678}) begin
        fails++;
        $display("[TB] FAIL store_wait: cycle %0d got req=%b we=%b addr=%h wdata=%h, required 1 1 00000200 12345678",
                 i, mem_req, mem_we, mem_addr, mem_wdata);
      end
      if (i == 1) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'h5A5A_5A5A;
      end
      @(negedge clk);
    end
    mem_ack   = 1'b0;
    mem_rdata = '0;
    checks++;
    if ({wb_valid, mem_req, mem_we, mem_wdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      fails++;
      $display("[TB] FAIL store_resp: got wbv=%b req=%b we=%b wdata=%h, required 1 0 0 00000000",
               wb_valid, mem_req, mem_we, mem_wdata);
    end
    @(negedge clk);
  endtask

  task automatic test_ack_outside_wait();
    int c0;
    c0        = wb_count;
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = '0;
    @(negedge clk);
    checks++;
    if ({wb_valid, mem_req, in_ready} !== 3'b001 || wb_count != c0) begin
      fails++;
      $display("[TB] FAIL stray_ack: got wbv=%b req=%b rdy=%b pulses=%0d, required 0 0 1 pulses=%0d",
               wb_valid, mem_req, in_ready, wb_count, c0);
    end
  endtask

  task automatic test_reset_in_wait();
    int c0;
    c0 = wb_count;
    drive_op(1'b1, 1'b0, 32'h0000_0400, 32'h0, 5'd9);
    checks++;
    if (mem_req !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_wait_entry: got mem_req=%b, required 1", mem_req);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_req, in_ready, wb_valid} !== 3'b000) begin
      fails++;
      $display("[TB] FAIL reset_wait_abort: got req=%b rdy=%b wbv=%b, required 0 0 0", mem_req, in_ready, wb_valid);
    end
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h1111_1111;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = '0;
    @(negedge clk);
    checks++;
    if ({wb_valid, mem_req, in_ready} !== 3'b001 || wb_count != c0) begin
      fails++;
      $display("[TB] FAIL reset_wait_late_ack: got wbv=%b req=%b rdy=%b pulses=%0d, required 0 0 1 pulses=%0d",
               wb_valid, mem_req, in_ready, wb_count, c0);
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    exp_q.push_back('{rd: 5'd10, data: 32'h0, en: 1'b0, err: 1'b1});
    drive_op(1'b1, 1'b0, 32'h0000_0500, 32'h0, 5'd10);
    for (int i = 0; i < TB_TIMEOUT; i++) begin
      checks++;
      if ({mem_req, in_ready} !== 2'b10) begin
        fails++;
        $display("[TB] FAIL timeout_wait: cycle %0d got req=%b rdy=%b, required 1 0", i, mem_req, in_ready);
      end
      @(negedge clk);
    end
    checks++;
    if ({mem_req, wb_valid, err, wb_en} !== 4'b0110) begin
      fails++;
      $display("[TB] FAIL timeout_abort: got req=%b wbv=%b err=%b en=%b, required 0 1 1 0",
               mem_req, wb_valid, err, wb_en);
    end
    @(negedge clk);
  endtask
`else
  task automatic test_no_timeout();
    exp_q.push_back('{rd: 5'd10, data: 32'h0F0F_0F0F, en: 1'b1, err: 1'b0});
    drive_op(1'b1, 1'b0, 32'h0000_0500, 32'h0, 5'd10);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({mem_req, in_ready, wb_valid} !== 3'b100) begin
        fails++;
        $display("[TB] FAIL long_wait: cycle %0d got req=%b rdy=%b wbv=%b, required 1 0 0",
                 i, mem_req, in_ready, wb_valid);
      end
      if (i == 19) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'h0F0F_0F0F;
      end
      @(negedge clk);
    end
    mem_ack   = 1'b0;
    mem_rdata = '0;
    checks++;
    if ({wb_valid, err} !== 2'b10) begin
      fails++;
      $display("[TB] FAIL long_wait_resp: got wbv=%b err=%b, required 1 0", wb_valid, err);
    end
    @(negedge clk);
  endtask
`endif

  task automatic test_back_to_back();
    for (int n = 0; n < 10; n++) begin
      int          op;
      int          delay;
      int          k;
      logic        ld;
      logic        st;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [4:0]  rd;
      op    = $urandom_range(0, 2);
      delay = $urandom_range(1, 3);
      ld    = (op == 1);
      st    = (op == 2);
      addr  = $urandom;
      wdata = $urandom;
      rdata = $urandom;
      rd    = 5'($urandom_range(0, 31));
      k     = 0;
      while (in_ready !== 1'b1 && k < 20) begin
        @(negedge clk);
        k++;
      end
      if (k == 20) begin
        checks++;
        fails++;
        $display("[TB] FAIL b2b_ready_timeout: got in_ready=%b after 20 cycles, required 1", in_ready);
      end
      exp_q.push_back('{rd: rd, data: (ld ? rdata : addr), en: (!st && rd != 5'd0), err: 1'b0});
      drive_op(ld, st, addr, wdata, rd);
      if (ld || st) begin
        for (int d = 0; d < delay; d++) begin
          if (d == delay - 1) begin
            mem_ack   = 1'b1;
            mem_rdata = rdata;
          end
          @(negedge clk);
        end
        mem_ack   = 1'b0;
        mem_rdata = '0;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    is_load    = 1'b0;
    is_s_instr = 1'b0;
    alu_result = '0;
    store_data = '0;
    rd_in      = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;

    test_reset();
    test_alu();
    test_load();
    test_both_flags();
    test_store();
    test_ack_outside_wait();
    test_reset_in_wait();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_back_to_back();

    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending writebacks, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
